// File: rtl/serial_subtractor_pkg.sv
// Shared arithmetic types for the serial subtractor family.
// Provides the control FSM state encoding and the counter-width helper.
package arith_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Bit counter must hold 0..WIDTH-1; sized for 0..WIDTH
    function automatic int cnt_width(int w);
        return $clog2(w + 1);
    endfunction

    localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/serial_subtractor_if.sv
// Start/busy/done handshake and operand/result bus of the serial subtractor.
// master: controller drives start/a/b/bin; slave: subtractor drives results.
interface serial_subtractor_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             ovf;

    modport master (
        output start, a, b, bin,
        input  busy, done, diff, bout, ovf
    );

    modport slave (
        input  start, a, b, bin,
        output busy, done, diff, bout, ovf
    );
endinterface

// File: rtl/full_subtractor_cell.sv
// 1-bit full subtractor: d = a - b - bi, bo = borrow out.
// Ports: a, b, bi in; d, bo out. Purely combinational.
module full_subtractor_cell (
    input  logic a,
    input  logic b,
    input  logic bi,
    output logic d,
    output logic bo
);
    assign d  = a ^ b ^ bi;
    assign bo = (~a & b) | (~a & bi) | (b & bi);
endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor, LSB first, one bit per clock.
// Ports: clk, rst_n (sync, active low), bus (slave: start/a/b/bin in, busy/done/diff/bout/ovf out).
module serial_subtractor
    import arith_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    serial_subtractor_if.slave bus
);
    localparam int CW = cnt_width(WIDTH);

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] r_sr;
    logic [WIDTH-1:0] r_nxt;
    logic [WIDTH-1:0] diff_q;
    logic [CW-1:0]    cnt;
    logic             brw;
    logic             bout_q;
    logic             ovf_q;
    logic             d;
    logic             bo;
    logic             last;
    logic             accept;
    logic             busy;
    logic             done;

    full_subtractor_cell u_cell (
        .a  (a_sr[0]),
        .b  (b_sr[0]),
        .bi (brw),
        .d  (d),
        .bo (bo)
    );

    assign last   = (cnt == CW'(WIDTH - 1));
    assign accept = bus.start && (state_q == IDLE || state_q == DONE);

    // Difference bits enter at the MSB so the LSB lands at bit 0 after WIDTH shifts
    generate
        if (WIDTH == 1) begin : g_w1
            assign r_nxt = d;
        end else begin : g_wn
            assign r_nxt = {d, r_sr[WIDTH-1:1]};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    state_d = bus.start ? SHIFT : IDLE;
            SHIFT:   state_d = last ? DONE : SHIFT;
            DONE:    state_d = bus.start ? SHIFT : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        unique case (state_q)
            SHIFT:   busy = 1'b1;
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_sr   <= '0;
            b_sr   <= '0;
            r_sr   <= '0;
            brw    <= 1'b0;
            cnt    <= '0;
            diff_q <= '0;
            bout_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else if (accept) begin
            a_sr <= bus.a;
            b_sr <= bus.b;
            r_sr <= '0;
            brw  <= bus.bin;
            cnt  <= '0;
        end else if (state_q == SHIFT) begin
            a_sr <= a_sr >> 1;
            b_sr <= b_sr >> 1;
            r_sr <= r_nxt;
            brw  <= bo;
            cnt  <= cnt + CW'(1);
            if (last) begin
                diff_q <= r_nxt;
                bout_q <= bo;
                // brw still holds the borrow into the MSB here
                ovf_q  <= brw ^ bo;
            end
        end
    end

    assign bus.busy = busy;
    assign bus.done = done;
    assign bus.diff = diff_q;
    assign bus.bout = bout_q;
    assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor at WIDTH 8, 4 and 1.
// Expected results are queued on each accepted start and checked on done.
module tb_serial_subtractor;

    typedef struct {
        logic [63:0] d;
        logic        bo;
        logic        ov;
        int          due;
    } exp_t;

    logic clk = 1'b0;
    logic rst8;
    logic rst4;
    logic rst1;
    int   cyc = 0;
    int   vecs = 0;
    int   errs = 0;
    int   bc8 = 0;
    int   bc4 = 0;
    int   bc1 = 0;
    bit   scr8 = 1'b0;
    exp_t q8[$];
    exp_t q4[$];
    exp_t q1[$];
    exp_t e8;
    exp_t e4;
    exp_t e1;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    serial_subtractor_if #(.WIDTH(8)) if8 ();
    serial_subtractor_if #(.WIDTH(4)) if4 ();
    serial_subtractor_if #(.WIDTH(1)) if1 ();

    serial_subtractor #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst8), .bus(if8));
    serial_subtractor #(.WIDTH(4)) dut4 (.clk(clk), .rst_n(rst4), .bus(if4));
    serial_subtractor #(.WIDTH(1)) dut1 (.clk(clk), .rst_n(rst1), .bus(if1));

    task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
        vecs++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Independent reference: integer arithmetic, signed range test for overflow
    function automatic exp_t ref_sub(int w, longint a, longint b, bit bin, int due);
        exp_t   e;
        longint m;
        longint sa;
        longint sb;
        longint sr;
        m     = longint'(1) << w;
        e.d   = 64'((a - b - longint'(bin)) & (m - 1));
        e.bo  = (a < b + longint'(bin));
        sa    = (a >= m / 2) ? a - m : a;
        sb    = (b >= m / 2) ? b - m : b;
        sr    = sa - sb - longint'(bin);
        e.ov  = (sr < -(m / 2)) || (sr > m / 2 - 1);
        e.due = due;
        return e;
    endfunction

    task automatic go8(logic [7:0] a, logic [7:0] b, logic bin);
        int n = 0;
        @(negedge clk);
        while (if8.busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk("idle_wait8", 64'(if8.busy), 64'd0);
        if8.start = 1'b1;
        if8.a = a;
        if8.b = b;
        if8.bin = bin;
        @(posedge clk);
        #1;
        q8.push_back(ref_sub(8, longint'(a), longint'(b), bin, cyc + 8));
        if8.start = 1'b0;
    endtask

    task automatic go4(logic [3:0] a, logic [3:0] b, logic bin);
        int n = 0;
        @(negedge clk);
        while (if4.busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk("idle_wait4", 64'(if4.busy), 64'd0);
        if4.start = 1'b1;
        if4.a = a;
        if4.b = b;
        if4.bin = bin;
        @(posedge clk);
        #1;
        q4.push_back(ref_sub(4, longint'(a), longint'(b), bin, cyc + 4));
        if4.start = 1'b0;
    endtask

    task automatic go1(logic a, logic b, logic bin);
        int n = 0;
        @(negedge clk);
        while (if1.busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk("idle_wait1", 64'(if1.busy), 64'd0);
        if1.start = 1'b1;
        if1.a = a;
        if1.b = b;
        if1.bin = bin;
        @(posedge clk);
        #1;
        q1.push_back(ref_sub(1, longint'(a), longint'(b), bin, cyc + 1));
        if1.start = 1'b0;
    endtask

    task automatic drain8();
        int n = 0;
        while ((q8.size() != 0 || if8.busy) && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("drain8", 64'(q8.size()), 64'd0);
    endtask

    always @(negedge clk) begin
        if (if8.done) begin
            if (q8.size() == 0) begin
                chk("spurious_done8", 64'd1, 64'd0);
            end else begin
                e8 = q8.pop_front();
                chk("diff8", 64'(if8.diff), e8.d);
                chk("bout8", 64'(if8.bout), 64'(e8.bo));
                chk("ovf8", 64'(if8.ovf), 64'(e8.ov));
                chk("latency8", 64'(cyc), 64'(e8.due));
                chk("busy_len8", 64'(bc8), 64'd8);
            end
            bc8 = 0;
        end else if (if8.busy) bc8++;
        else bc8 = 0;
    end

    always @(negedge clk) begin
        if (if4.done) begin
            if (q4.size() == 0) begin
                chk("spurious_done4", 64'd1, 64'd0);
            end else begin
                e4 = q4.pop_front();
                chk("diff4", 64'(if4.diff), e4.d);
                chk("bout4", 64'(if4.bout), 64'(e4.bo));
                chk("ovf4", 64'(if4.ovf), 64'(e4.ov));
                chk("latency4", 64'(cyc), 64'(e4.due));
                chk("busy_len4", 64'(bc4), 64'd4);
            end
            bc4 = 0;
        end else if (if4.busy) bc4++;
        else bc4 = 0;
    end

    always @(negedge clk) begin
        if (if1.done) begin
            if (q1.size() == 0) begin
                chk("spurious_done1", 64'd1, 64'd0);
            end else begin
                e1 = q1.pop_front();
                chk("diff1", 64'(if1.diff), e1.d);
                chk("bout1", 64'(if1.bout), 64'(e1.bo));
                chk("ovf1", 64'(if1.ovf), 64'(e1.ov));
                chk("latency1", 64'(cyc), 64'(e1.due));
                chk("busy_len1", 64'(bc1), 64'd1);
            end
            bc1 = 0;
        end else if (if1.busy) bc1++;
        else bc1 = 0;
    end

    // Operands wander while a latched operation is in flight
    always @(negedge clk) begin
        if (scr8 && if8.busy) begin
            if8.a = 8'($urandom);
            if8.b = 8'($urandom);
        end
    end

    initial begin
        if8.start = 1'b0; if8.a = '0; if8.b = '0; if8.bin = 1'b0;
        if4.start = 1'b0; if4.a = '0; if4.b = '0; if4.bin = 1'b0;
        if1.start = 1'b0; if1.a = '0; if1.b = '0; if1.bin = 1'b0;
        rst8 = 1'b0;
        rst4 = 1'b0;
        rst1 = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy8", 64'(if8.busy), 64'd0);
        chk("rst_done8", 64'(if8.done), 64'd0);
        chk("rst_diff8", 64'(if8.diff), 64'd0);
        chk("rst_bout8", 64'(if8.bout), 64'd0);
        chk("rst_ovf8", 64'(if8.ovf), 64'd0);
        chk("rst_diff4", 64'(if4.diff), 64'd0);
        chk("rst_busy1", 64'(if1.busy), 64'd0);
        rst8 = 1'b1;
        rst4 = 1'b1;
        rst1 = 1'b1;

        fork
            begin
                go8(8'h5A, 8'h3C, 1'b0);
                go8(8'h00, 8'h01, 1'b0);
                go8(8'h80, 8'h01, 1'b0);
                go8(8'h7F, 8'hFF, 1'b0);
                go8(8'h10, 8'h0F, 1'b1);
                drain8();

                // start held high: accepts only at the DONE edges
                @(negedge clk);
                if8.start = 1'b1;
                if8.a = 8'h10;
                if8.b = 8'h0F;
                if8.bin = 1'b1;
                @(posedge clk);
                #1;
                q8.push_back(ref_sub(8, 64'h10, 64'h0F, 1'b1, cyc + 8));
                repeat (2) begin
                    repeat (9) @(posedge clk);
                    #1;
                    q8.push_back(ref_sub(8, 64'h10, 64'h0F, 1'b1, cyc + 8));
                end
                if8.start = 1'b0;
                drain8();

                scr8 = 1'b1;
                go8(8'hA5, 8'h5A, 1'b1);
                go8(8'h01, 8'hC3, 1'b0);
                drain8();
                scr8 = 1'b0;

                // reset during the 4th SHIFT cycle discards the operation
                @(negedge clk);
                if8.start = 1'b1;
                if8.a = 8'h5A;
                if8.b = 8'h3C;
                if8.bin = 1'b0;
                @(posedge clk);
                #1;
                if8.start = 1'b0;
                repeat (4) @(negedge clk);
                rst8 = 1'b0;
                @(negedge clk);
                chk("midrst_busy8", 64'(if8.busy), 64'd0);
                chk("midrst_done8", 64'(if8.done), 64'd0);
                chk("midrst_diff8", 64'(if8.diff), 64'd0);
                chk("midrst_bout8", 64'(if8.bout), 64'd0);
                chk("midrst_ovf8", 64'(if8.ovf), 64'd0);
                rst8 = 1'b1;
                repeat (12) @(negedge clk);
                go8(8'h03, 8'h05, 1'b0);
                drain8();
            end
            begin
                for (int a = 0; a < 16; a++)
                    for (int b = 0; b < 16; b++)
                        for (int c = 0; c < 2; c++)
                            go4(4'(a), 4'(b), 1'(c));
            end
            begin
                for (int a = 0; a < 2; a++)
                    for (int b = 0; b < 2; b++)
                        for (int c = 0; c < 2; c++)
                            go1(1'(a), 1'(b), 1'(c));
            end
        join

        repeat (12) @(negedge clk);
        chk("pending8", 64'(q8.size()), 64'd0);
        chk("pending4", 64'(q4.size()), 64'd0);
        chk("pending1", 64'(q1.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
